// File: rtl/axis_pkg.sv
// Shared types and default widths for the AXI-Stream packet generator.
package axis_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_LEN_WIDTH  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/axis_packet_gen_if.sv
// Command + AXI-Stream bundle for axis_packet_gen.
//   master modport : generator side (accepts commands, drives the stream)
//   slave modport  : environment side (issues commands, sinks the stream)
interface axis_packet_gen_if
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = DEFAULT_LEN_WIDTH
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [DATA_WIDTH-1:0] cmd_start;
  logic [DATA_WIDTH-1:0] cmd_step;

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (
    input  cmd_valid, cmd_len, cmd_start, cmd_step, tready,
    output cmd_ready, tvalid, tdata, tlast
  );

  modport slave (
    output cmd_valid, cmd_len, cmd_start, cmd_step, tready,
    input  cmd_ready, tvalid, tdata, tlast
  );

endinterface

// File: rtl/axis_packet_gen.sv
// AXI-Stream packet generator: one accepted command produces cmd_len+1 beats
// of an arithmetic sequence (cmd_start, +cmd_step, ...), tlast on the final beat.
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset
//   bus (master)  : cmd_valid/cmd_ready/cmd_len/cmd_start/cmd_step,
//                   tvalid/tready/tdata/tlast
//   busy          : packet in progress
//   done          : one-cycle pulse after the final beat handshake
// All outputs come straight from flops.
module axis_packet_gen
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  axis_packet_gen_if.master      bus,
  output logic                   busy,
  output logic                   done
);

  state_e                state_q, state_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tdata_d     = tdata_q;
    step_d      = step_q;
    remaining_d = remaining_q;
    cmd_ready_d = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        // cmd_ready_q is low on the first cycle out of reset, so no accept there
        if (bus.cmd_valid && cmd_ready_q) begin
          state_d     = SEND;
          tvalid_d    = 1'b1;
          tdata_d     = bus.cmd_start;
          tlast_d     = (bus.cmd_len == '0);
          remaining_d = bus.cmd_len;
          step_d      = bus.cmd_step;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end

      SEND: begin
        if (tvalid_q && bus.tready) begin
          if (tlast_q) begin
            state_d     = IDLE;
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            done_d      = 1'b1;
            cmd_ready_d = 1'b1;
          end else begin
            // remaining counts beats still to follow; it reaches zero on the
            // final beat, so a full 2^LEN_WIDTH packet never wraps it
            tdata_d     = tdata_q + step_q;
            remaining_d = remaining_q - LEN_WIDTH'(1);
            tlast_d     = (remaining_q == LEN_WIDTH'(1));
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SEND);
  end

  // State and output registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      step_q      <= '0;
      remaining_q <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tdata_q     <= tdata_d;
      step_q      <= step_d;
      remaining_q <= remaining_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.tvalid    = tvalid_q;
  assign bus.tlast     = tlast_q;
  assign bus.tdata     = tdata_q;
  assign bus.cmd_ready = cmd_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_axis_packet_gen.sv
// Bench for axis_packet_gen: directed and randomized packets checked against
// an arithmetic model of the expected beat sequence.
module tb_axis_packet_gen;

  localparam int unsigned DW = 8;
  localparam int unsigned LW = 8;

  logic aclk = 1'b0;
  logic aresetn;
  logic busy;
  logic done;

  axis_packet_gen_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  axis_packet_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .bus    (bus.master),
    .busy   (busy),
    .done   (done)
  );

  always #5 aclk = ~aclk;

  int unsigned total  = 0;
  int unsigned passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Model: beat k of a packet is start + k*step modulo 2^DW
  function automatic logic [DW-1:0] beat_data(input logic [DW-1:0] start,
                                             input logic [DW-1:0] step,
                                             input int unsigned k);
    int unsigned v;
    v = (32'(start) + k * 32'(step)) % (32'd1 << DW);
    return DW'(v);
  endfunction

  // Issue one command (entered and left on a falling edge) and follow the packet.
  // mode 0: tready always 1; mode 1: tready 1,0,0,1,1 then 1; mode 2: random.
  task automatic run_packet(input int unsigned len, input logic [DW-1:0] start,
                            input logic [DW-1:0] step, input int mode,
                            input bit keep_valid);
    int unsigned k;
    int unsigned c;
    int unsigned budget;
    bit          hs;
    logic [4:0]  pat;
    pat    = 5'b11001;
    budget = 0;
    while (!bus.cmd_ready && budget < 20) begin
      @(negedge aclk);
      budget++;
    end
    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LW'(len);
    bus.cmd_start = start;
    bus.cmd_step  = step;
    @(negedge aclk);
    if (!keep_valid) bus.cmd_valid = 1'b0;
    check("accept_latency_tvalid", 32'(bus.tvalid), 32'd1);
    check("done_after_accept", 32'(done), 32'd0);
    k = 0;
    c = 0;
    while (k <= len && c < (len + 1) * 8 + 50) begin
      check("tvalid", 32'(bus.tvalid), 32'd1);
      check("tdata", 32'(bus.tdata), 32'(beat_data(start, step, k)));
      check("tlast", 32'(bus.tlast), 32'(k == len));
      check("busy", 32'(busy), 32'd1);
      check("cmd_ready_send", 32'(bus.cmd_ready), 32'd0);
      check("done_send", 32'(done), 32'd0);
      case (mode)
        0:       hs = 1'b1;
        1:       hs = (c < 5) ? pat[c] : 1'b1;
        default: hs = 1'($urandom_range(0, 1));
      endcase
      bus.tready = hs;
      @(negedge aclk);
      c++;
      if (hs) k++;
    end
    check("beat_count", k, len + 1);
    check("done_pulse", 32'(done), 32'd1);
    check("tvalid_after_last", 32'(bus.tvalid), 32'd0);
    check("tlast_after_last", 32'(bus.tlast), 32'd0);
    check("busy_after_last", 32'(busy), 32'd0);
    check("cmd_ready_after_last", 32'(bus.cmd_ready), 32'd1);
    check("tdata_held_after_last", 32'(bus.tdata), 32'(beat_data(start, step, len)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.cmd_start = '0;
    bus.cmd_step  = '0;
    bus.tready    = 1'b1;

    // Reset values
    @(negedge aclk);
    check("rst_tvalid", 32'(bus.tvalid), 32'd0);
    check("rst_tlast", 32'(bus.tlast), 32'd0);
    check("rst_tdata", 32'(bus.tdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    aresetn = 1'b1;
    #1;
    check("cmd_ready_before_edge", 32'(bus.cmd_ready), 32'd0);
    @(negedge aclk);
    check("cmd_ready_after_release", 32'(bus.cmd_ready), 32'd1);
    check("tvalid_idle", 32'(bus.tvalid), 32'd0);

    // Directed packets
    run_packet(3, 8'h10, 8'h01, 0, 1'b0);
    run_packet(0, 8'hAA, 8'h55, 0, 1'b0);
    run_packet(2, 8'hFE, 8'h01, 1, 1'b0);
    run_packet(255, 8'($urandom), 8'h03, 2, 1'b0);

    // Randomized packets
    repeat (6) run_packet($urandom_range(0, 20), 8'($urandom), 8'($urandom), 2, 1'b0);

    // Reset during a 5-beat packet, after two beats have gone
    bus.tready    = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LW'(4);
    bus.cmd_start = 8'h40;
    bus.cmd_step  = 8'h07;
    @(negedge aclk);
    bus.cmd_valid = 1'b0;
    check("rstmid_beat0", 32'(bus.tdata), 32'h40);
    @(negedge aclk);
    check("rstmid_beat1", 32'(bus.tdata), 32'h47);
    @(negedge aclk);
    check("rstmid_beat2_valid", 32'(bus.tvalid), 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check("rstmid_tvalid", 32'(bus.tvalid), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_tlast", 32'(bus.tlast), 32'd0);
    check("rstmid_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    @(negedge aclk);
    check("rstmid_no_done", 32'(done), 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("rstmid_no_done_after", 32'(done), 32'd0);
    check("rstmid_idle_tvalid", 32'(bus.tvalid), 32'd0);
    run_packet(1, 8'h33, 8'h11, 0, 1'b0);

    // cmd_valid held high across two packets: one bubble between them
    run_packet(3, 8'h20, 8'h10, 2, 1'b1);
    run_packet(2, 8'h90, 8'hF0, 0, 1'b1);
    bus.cmd_valid = 1'b0;
    @(negedge aclk);
    check("no_extra_accept", 32'(bus.tvalid), 32'd0);
    check("done_single_cycle", 32'(done), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
